ysyx_23060208_idu_rx: RTL and testbench
=======================================

# ysyx_23060208_idu_rx

Receiving end of the IFU→IDU valid/ready channel. Accepts 64-bit `{pc, inst}` beats from the fetch unit into a 2-entry elastic buffer. Presents the head entry, with decoded RV32 fields, to the EXU over a second valid/ready channel. A redirect from the EXU flushes all buffered instructions.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `pc` and `inst`.

Ports:
- `clk`  in  1  clock; everything is sampled on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `ifu_to_idu_valid`  in  1  IFU has a beat on the data bus.
- `ifu_to_idu_data_i`  in  2*DATA_WIDTH  `{pc[63:32], inst[31:0]}`.
- `idu_to_ifu_ready`  out  1  buffer can accept a beat this cycle.
- `exu_nextpc_taken`  in  1  redirect; flush all buffered entries.
- `idu_to_exu_valid`  out  1  head entry valid.
- `exu_to_idu_ready`  in  1  EXU consumes the head this cycle.
- `idu_pc`, `idu_inst`  out  DATA_WIDTH each  head entry contents.
- `idu_rd`, `idu_rs1`, `idu_rs2`  out  5 each  `inst[11:7]`, `inst[19:15]`, `inst[24:20]`.
- `idu_funct3`  out  3  `inst[14:12]`.
- `idu_funct7`  out  7  `inst[31:25]`.
- `idu_opcode`  out  7  `inst[6:0]`.
- `idu_imm`  out  DATA_WIDTH  sign-extended immediate.
- `idu_illegal`  out  1  opcode not in the supported set.

## Operation
- Storage: two entries, each holding 2*DATA_WIDTH bits.
- Occupancy FSM has three states: EMPTY, ONE, FULL.
- Push: `ifu_to_idu_valid && idu_to_ifu_ready`.
- Pop: `idu_to_exu_valid && exu_to_idu_ready`.
- `idu_to_ifu_ready = (state != FULL)`. It depends only on registered state, with no combinational path from `exu_to_idu_ready`.
- `idu_to_exu_valid = (state != EMPTY)`.
- Transitions with no flush:
  - EMPTY: push → ONE; otherwise stay.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE, and the new beat becomes the head.
  - FULL: pop → ONE, and the second entry becomes the head. No push is possible.
- Ordering is strict FIFO: a head/tail pointer pair, or a shift from entry 1 to entry 0 on pop.
- Flush: `exu_nextpc_taken=1` forces the next state to EMPTY. It overrides any same-cycle push and pop, so an incoming beat in that cycle is discarded.
- Decode is purely combinational from the head entry:
  - I-type immediate for opcodes 0010011, 0000011, 1100111, 1110011: sext(`inst[31:20]`).
  - S-type, opcode 0100011: sext(`{inst[31:25], inst[11:7]}`).
  - B-type, opcode 1100011: sext(`{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`).
  - U-type, opcodes 0110111 and 0010111: `{inst[31:12], 12'b0}`.
  - J-type, opcode 1101111: sext(`{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`).
  - R-type, opcode 0110011: imm = 0, legal.
  - Any other opcode: imm = 0, `idu_illegal=1`.
- Decoded outputs are don't-care while `idu_to_exu_valid=0`, but they must still be driven from the head entry storage, never X.

## Timing
- Reset, i.e. `rst=0` at an edge, sets:
  - state = EMPTY and both entries = 0;
  - `idu_to_ifu_ready=1` and `idu_to_exu_valid=0` in the following cycle;
  - all data and decoded outputs = 0 (so `idu_illegal=1`, since opcode 0 is unsupported).
- Reset mid-operation drops all entries, identical to flush, and takes priority over flush.
- Latency: a beat pushed at edge N is visible on `idu_*` with `idu_to_exu_valid=1` in the cycle after edge N, provided the buffer was empty. There is no combinational bypass from input to output.
- Throughput: 1 beat per cycle sustained when `exu_to_idu_ready` is held high.
- The bus is stall-free under backpressure: with EXU stalled, two beats are absorbed before `idu_to_ifu_ready` falls.
- Handshake rules:
  - The IFU must hold its data while valid is high and ready is low.
  - The block holds `idu_*` stable while `idu_to_exu_valid=1` and `exu_to_idu_ready=0`.
- Flush at edge N: `idu_to_exu_valid=0` and `idu_to_ifu_ready=1` in the cycle after N.

## Structure
- Shared package `ysyx_23060208_pkg` holds:
  - the opcode constants (OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP);
  - the state encoding: 2-bit, EMPTY=0, ONE=1, FULL=2.
- One sub-module, `ysyx_23060208_imm_gen`: combinational, `inst` in, imm and illegal out. It is reused later by the EXU branch unit.
- The buffer and FSM live in the top module.

## Test plan
- Single beat, no backpressure:
  - Stimulus: push `{0x80000000, 0x00500093}` with EXU ready=1.
  - Required: next cycle valid=1, pc=0x80000000, rd=1, rs1=0, imm=5, illegal=0; following cycle valid=0.
- Backpressure:
  - Stimulus: EXU ready=0; push beats pc 0x80000000, 0x80000004, and offer 0x80000008.
  - Required: ready low after the second push and the third beat held; with EXU ready=1, pops come out in order 0x80000000, 0x80000004, 0x80000008.
- Simultaneous push and pop in state ONE:
  - Required: state stays ONE, and the head advances to the new pc the next cycle.
- Flush with concurrent push:
  - Stimulus: buffer FULL; assert `exu_nextpc_taken` together with a push of pc 0x80000010.
  - Required: next cycle valid=0, ready=1, and the beat is not delivered.
- Immediate decode:
  - Stimulus: head inst 0xFE000EE3 (beq x0,x0,-4).
  - Required: imm=0xFFFFFFFC.
  - Stimulus: head inst 0x0000000B.
  - Required: illegal=1, imm=0.
- Reset mid-operation:
  - Stimulus: `rst=0` for one edge while FULL and EXU stalled.
  - Required: valid=0, ready=1, all `idu_*` outputs =0 afterwards.

Source files
------------

// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the IDU receive path: RV32 opcode constants and the
// occupancy-state encoding of the IFU->IDU elastic buffer.
package ysyx_23060208_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } idu_state_e;

endpackage

// File: rtl/ysyx_23060208_imm_gen.sv
// Combinational RV32 immediate generator and supported-opcode check.
// Shared between the IDU and the EXU branch unit.
module ysyx_23060208_imm_gen
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (inst[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: imm32 = {{20{inst[31]}}, inst[31:20]};
      STORE:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      BRANCH:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      LUI, AUIPC: imm32 = {inst[31:12], 12'b0};
      JAL:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP:      imm32 = '0;
      default: illegal = 1'b1;
    endcase
  end

  // Sign-extend the 32-bit immediate to the datapath width.
  assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/ysyx_23060208_idu_rx.sv
// IDU receive stage: 2-entry elastic buffer between IFU and EXU, presenting
// the head entry with decoded RV32 fields. A redirect flushes all entries.
module ysyx_23060208_idu_rx
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_to_idu_valid,
  input  logic [2*DATA_WIDTH-1:0] ifu_to_idu_data_i,
  output logic                    idu_to_ifu_ready,
  input  logic                    exu_nextpc_taken,
  output logic                    idu_to_exu_valid,
  input  logic                    exu_to_idu_ready,
  output logic [DATA_WIDTH-1:0]   idu_pc,
  output logic [DATA_WIDTH-1:0]   idu_inst,
  output logic [4:0]              idu_rd,
  output logic [4:0]              idu_rs1,
  output logic [4:0]              idu_rs2,
  output logic [2:0]              idu_funct3,
  output logic [6:0]              idu_funct7,
  output logic [6:0]              idu_opcode,
  output logic [DATA_WIDTH-1:0]   idu_imm,
  output logic                    idu_illegal
);

  idu_state_e state, next_state;

  // entry0 is always the head; entry1 shifts into it on pop from FULL.
  logic [2*DATA_WIDTH-1:0] entry0, entry1;

  logic push, pop;
  logic load_head, head_from_tail, load_tail;

  assign idu_to_ifu_ready = (state != FULL);
  assign idu_to_exu_valid = (state != EMPTY);

  assign push = ifu_to_idu_valid && idu_to_ifu_ready;
  assign pop  = idu_to_exu_valid && exu_to_idu_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      state <= next_state;
      if (load_head) entry0 <= head_from_tail ? entry1 : ifu_to_idu_data_i;
      if (load_tail) entry1 <= ifu_to_idu_data_i;
    end
  end

  always_comb begin
    next_state     = state;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    if (exu_nextpc_taken) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            next_state = ONE;
            load_head  = 1'b1;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              next_state = FULL;
              load_tail  = 1'b1;
            end
            2'b01: next_state = EMPTY;
            2'b11: load_head = 1'b1;
            default: next_state = ONE;
          endcase
        end
        FULL: begin
          if (pop) begin
            next_state     = ONE;
            load_head      = 1'b1;
            head_from_tail = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  assign idu_pc     = entry0[2*DATA_WIDTH-1:DATA_WIDTH];
  assign idu_inst   = entry0[DATA_WIDTH-1:0];
  assign idu_rd     = idu_inst[11:7];
  assign idu_rs1    = idu_inst[19:15];
  assign idu_rs2    = idu_inst[24:20];
  assign idu_funct3 = idu_inst[14:12];
  assign idu_funct7 = idu_inst[31:25];
  assign idu_opcode = idu_inst[6:0];

  ysyx_23060208_imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .inst    (idu_inst[31:0]),
    .imm     (idu_imm),
    .illegal (idu_illegal)
  );

endmodule

// File: tb/tb_ysyx_23060208_idu_rx.sv
// Self-checking bench for ysyx_23060208_idu_rx: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ysyx_23060208_idu_rx;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2*DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pc, inst, imm;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7, opcode;
  logic          illegal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ysyx_23060208_idu_rx #(.DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifu_to_idu_valid  (in_valid),
    .ifu_to_idu_data_i (in_data),
    .idu_to_ifu_ready  (in_ready),
    .exu_nextpc_taken  (flush),
    .idu_to_exu_valid  (out_valid),
    .exu_to_idu_ready  (out_ready),
    .idu_pc            (pc),
    .idu_inst          (inst),
    .idu_rd            (rd),
    .idu_rs1           (rs1),
    .idu_rs2           (rs2),
    .idu_funct3        (funct3),
    .idu_funct7        (funct7),
    .idu_opcode        (opcode),
    .idu_imm           (imm),
    .idu_illegal       (illegal)
  );

  // Reference immediate built from weighted bit fields with integer arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int s;
    s = $signed(i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return s >>> 20;
      7'h23: return ((s >>> 25) * 32) + int'(i[11:7]);
      7'h63: return (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'h37, 7'h17: return i & 32'hFFFFF000;
      7'h6F: return (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
    return !(i[6:0] inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33});
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fails++;
      $display("FAIL reset_handshake: ready/valid got %b, want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({pc, inst, imm} !== '0) begin
      n_fails++;
      $display("FAIL reset_data: pc=%h inst=%h imm=%h, want all zero", pc, inst, imm);
    end
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_illegal: got %b want 1", illegal);
    end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {32'h80000000, 32'h00500093};
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, pc, rd, rs1, imm, illegal} !== {1'b1, 32'h80000000, 5'd1, 5'd0, 32'd5, 1'b0}) begin
      n_fails++;
      $display("FAIL single_beat: valid=%b pc=%h rd=%0d rs1=%0d imm=%h ill=%b, want 1 80000000 1 0 00000005 0",
               out_valid, pc, rd, rs1, imm, illegal);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL single_beat_drain: valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h80000000, 32'h00000013};
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b11) begin
      n_fails++;
      $display("FAIL bp_one_entry: ready/valid got %b want 11", {in_ready, out_valid});
    end
    in_data = {32'h80000004, 32'h00000013};
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_full_ready: got %b want 0", in_ready);
    end
    in_data = {32'h80000008, 32'h00000013};
    step();
    n_checks++;
    if ({in_ready, pc} !== {1'b0, 32'h80000000}) begin
      n_fails++;
      $display("FAIL bp_hold: ready=%b pc=%h, want 0 80000000", in_ready, pc);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({out_valid, pc} !== {1'b1, 32'h80000004}) begin
      n_fails++;
      $display("FAIL bp_pop1: valid=%b pc=%h, want 1 80000004", out_valid, pc);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, pc} !== {1'b1, 32'h80000008}) begin
      n_fails++;
      $display("FAIL bp_pop2: valid=%b pc=%h, want 1 80000008", out_valid, pc);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_empty: valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h80000020, 32'h00000033};
    step();
    out_ready = 1'b1;
    in_data   = {32'h80000024, 32'h00000033};
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, pc} !== {1'b1, 1'b1, 32'h80000024}) begin
      n_fails++;
      $display("FAIL push_pop_one: valid=%b ready=%b pc=%h, want 1 1 80000024", out_valid, in_ready, pc);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h80000030, 32'h00000013};
    step();
    in_data = {32'h80000034, 32'h00000013};
    step();
    in_data = {32'h80000010, 32'h00000013};
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL flush_state: valid/ready got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL flush_discard: valid got %b want 0 (pc=%h)", out_valid, pc);
    end
  endtask

  task automatic test_imm_decode();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h80000040, 32'hFE000EE3};
    step();
    n_checks++;
    if ({imm, illegal} !== {32'hFFFFFFFC, 1'b0}) begin
      n_fails++;
      $display("FAIL imm_branch: imm=%h ill=%b, want fffffffc 0", imm, illegal);
    end
    out_ready = 1'b1;
    in_data   = {32'h80000044, 32'h0000000B};
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, imm, illegal} !== {1'b1, 32'd0, 1'b1}) begin
      n_fails++;
      $display("FAIL imm_illegal: valid=%b imm=%h ill=%b, want 1 00000000 1", out_valid, imm, illegal);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h80000050, 32'hFFF00093};
    step();
    in_data = {32'h80000054, 32'h12345037};
    step();
    rst   = 1'b0;
    flush = 1'b1;
    step();
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL reset_mid_state: valid/ready got %b want 01", {out_valid, in_ready});
    end
    n_checks++;
    if ({pc, inst, imm, rd, rs1, rs2, funct3, funct7, opcode, illegal} !== {{(3 * DW + 32){1'b0}}, 1'b1}) begin
      n_fails++;
      $display("FAIL reset_mid_data: pc=%h inst=%h imm=%h ill=%b, want zeros and ill=1", pc, inst, imm, illegal);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0]   q[$];
    logic [2*DW-1:0] qd[$];
    logic [6:0]      ops[11];
    logic [31:0]     ri;
    logic [31:0]     h;
    logic            push_m, pop_m;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if ({in_ready, out_valid} !== {qd.size() < 2, qd.size() > 0}) begin
        n_fails++;
        $display("FAIL rand_handshake cyc=%0d: ready/valid got %b want %b", cyc,
                 {in_ready, out_valid}, {qd.size() < 2, qd.size() > 0});
      end
      if (qd.size() > 0) begin
        h = qd[0][31:0];
        n_checks++;
        if ({pc, inst, imm, illegal} !== {qd[0], ref_imm(h), ref_illegal(h)}) begin
          n_fails++;
          $display("FAIL rand_head cyc=%0d: pc=%h inst=%h imm=%h ill=%b, want %h %h %h %b", cyc,
                   pc, inst, imm, illegal, qd[0][63:32], h, ref_imm(h), ref_illegal(h));
        end
        n_checks++;
        if ({rd, rs1, rs2, funct3, funct7, opcode} !== {h[11:7], h[19:15], h[24:20], h[14:12], h[31:25], h[6:0]}) begin
          n_fails++;
          $display("FAIL rand_fields cyc=%0d: inst=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h op=%h",
                   cyc, h, rd, rs1, rs2, funct3, funct7, opcode);
        end
      end
      // A beat offered but not taken must be held unchanged.
      if (!(in_valid && qd.size() >= 2)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        ri = $urandom;
        ri[6:0] = ops[$urandom_range(0, 10)];
        in_data = {32'h80000000 + 32'($urandom_range(0, 4095)) * 4, ri};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      push_m = in_valid && (qd.size() < 2);
      pop_m  = (qd.size() > 0) && out_ready;
      step();
      if (flush) begin
        qd.delete();
      end else begin
        if (pop_m) void'(qd.pop_front());
        if (push_m) qd.push_back(in_data);
      end
    end
    q.delete();
    idle();
    drain();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_single_beat();
    drain();
    test_backpressure();
    drain();
    test_push_pop_one();
    drain();
    test_flush();
    drain();
    test_imm_decode();
    drain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
